// File: rtl/emon_mcounter.sv
// emon_mcounter: eLink traffic monitor with MONS independent event counters on the mi_* bus.
// Each monitor has an event select, up/down direction, wrap/saturate mode and a sticky flag.
// The monitor also has an interrupt enable and shares a global freeze/clear control.
// Optional feature macro: EMON_SNAPSHOT_EN. When it is defined, ctrl[2] copies all counters
// into shadow registers, which are read back at 0x30+i.
module emon_mcounter #(
  parameter int unsigned DW   = 32,
  parameter int unsigned CW   = 32,
  parameter int unsigned MONS = 6,
  parameter int unsigned EW   = 12,
  parameter int unsigned SELW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mi_access,
  input  logic            mi_write,
  input  logic [5:0]      mi_addr,
  input  logic [DW-1:0]   mi_data_in,
  output logic [DW-1:0]   mi_data_out,
  input  logic [EW-1:0]   emon_events,
  output logic [MONS-1:0] emon_zero_flag,
  output logic            emon_irq
);

  localparam int unsigned EVW = EW + 2;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [5:0] ADDR_CTRL = 6'h20;
  localparam logic [5:0] ADDR_STAT = 6'h21;

  logic [MONS-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [MONS-1:0][SELW-1:0] sel_q, sel_d;
  logic [MONS-1:0]           en_q, en_d;
  logic [MONS-1:0]           dir_q, dir_d;
  logic [MONS-1:0]           sat_q, sat_d;
  logic [MONS-1:0]           irqen_q, irqen_d;
  logic [MONS-1:0]           flag_q, flag_d;
  logic                      gen_q, gen_d;
  logic                      irq_q, irq_d;
  logic [DW-1:0]             rdata_q, rdata_d;

  logic                      wr_c, rd_c, ctrl_wr_c, stat_wr_c, clear_all_c;
  logic [MONS-1:0]           cnt_wr_c, cfg_wr_c, ev_hit_c, flag_set_c;
  logic [EVW-1:0]            ev_vec_c;
  logic [DW-1:0]             rsel_c;
  logic                      unused_c;

  assign wr_c        = mi_access & mi_write;
  assign rd_c        = mi_access & ~mi_write;
  assign ctrl_wr_c   = wr_c && (mi_addr == ADDR_CTRL);
  assign stat_wr_c   = wr_c && (mi_addr == ADDR_STAT);
  assign clear_all_c = ctrl_wr_c & mi_data_in[1];
  assign ev_vec_c    = {emon_events, 1'b1, 1'b0};
  assign unused_c    = ^mi_data_in;

  // Per-monitor write strobes for counter and config registers
  always_comb begin
    cnt_wr_c = '0;
    cfg_wr_c = '0;
    for (int i = 0; i < int'(MONS); i++) begin
      cnt_wr_c[i] = wr_c && (mi_addr == 6'(i));
      cfg_wr_c[i] = wr_c && (mi_addr == 6'(16 + i));
    end
  end

  // Event selection; selects beyond the event vector never count
  always_comb begin
    ev_hit_c = '0;
    for (int i = 0; i < int'(MONS); i++) begin
      for (int k = 0; k < int'(EVW); k++) begin
        if (sel_q[i] == SELW'(k)) ev_hit_c[i] = ev_vec_c[k];
      end
    end
  end

  // Config and global control next state
  always_comb begin
    sel_d   = sel_q;
    en_d    = en_q;
    dir_d   = dir_q;
    sat_d   = sat_q;
    irqen_d = irqen_q;
    gen_d   = ctrl_wr_c ? mi_data_in[0] : gen_q;
    for (int i = 0; i < int'(MONS); i++) begin
      if (cfg_wr_c[i]) begin
        sel_d[i]   = mi_data_in[SELW-1:0];
        en_d[i]    = mi_data_in[8];
        dir_d[i]   = mi_data_in[9];
        sat_d[i]   = mi_data_in[10];
        irqen_d[i] = mi_data_in[11];
      end
    end
  end

  // Counter update: clear_all beats a bus write, which beats counting
  always_comb begin
    cnt_d      = cnt_q;
    flag_set_c = '0;
    for (int i = 0; i < int'(MONS); i++) begin
      if (clear_all_c) begin
        cnt_d[i] = '0;
      end else if (cnt_wr_c[i]) begin
        cnt_d[i] = mi_data_in[CW-1:0];
      end else if (gen_q && en_q[i] && ev_hit_c[i]) begin
        if (!dir_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            cnt_d[i]      = sat_q[i] ? CNT_MAX : '0;
            flag_set_c[i] = ~sat_q[i];
          end else begin
            cnt_d[i]      = cnt_q[i] + CW'(1);
            flag_set_c[i] = sat_q[i] && (cnt_q[i] == CNT_MAX - CW'(1));
          end
        end else begin
          if (cnt_q[i] == '0) begin
            cnt_d[i]      = sat_q[i] ? '0 : CNT_MAX;
            flag_set_c[i] = ~sat_q[i];
          end else begin
            cnt_d[i]      = cnt_q[i] - CW'(1);
            flag_set_c[i] = (cnt_q[i] == CW'(1));
          end
        end
      end
    end
  end

  // Sticky flags: W1C, a same-cycle set wins, clear_all wipes everything
  always_comb begin
    flag_d = (flag_q & ~(stat_wr_c ? mi_data_in[MONS-1:0] : '0)) | flag_set_c;
    if (clear_all_c) flag_d = '0;
    irq_d = |(flag_d & irqen_d);
  end

`ifdef EMON_SNAPSHOT_EN
  logic [MONS-1:0][CW-1:0] shadow_q, shadow_d;
  logic                    snap_c;

  assign snap_c = ctrl_wr_c & mi_data_in[2];

  // Snapshot captures the pre-update counter values
  always_comb begin
    shadow_d = snap_c ? cnt_q : shadow_q;
  end

  // Shadow registers survive clear_all, only reset clears them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shadow_q <= '0;
    else          shadow_q <= shadow_d;
  end
`endif

  // Read mux over the register map; unmapped addresses read 0
  always_comb begin
    rsel_c = '0;
    for (int i = 0; i < int'(MONS); i++) begin
      if (mi_addr == 6'(i)) rsel_c = DW'(cnt_q[i]);
      if (mi_addr == 6'(16 + i)) begin
        rsel_c             = '0;
        rsel_c[SELW-1:0]   = sel_q[i];
        rsel_c[8]          = en_q[i];
        rsel_c[9]          = dir_q[i];
        rsel_c[10]         = sat_q[i];
        rsel_c[11]         = irqen_q[i];
      end
`ifdef EMON_SNAPSHOT_EN
      if (mi_addr == 6'(48 + i)) rsel_c = DW'(shadow_q[i]);
`endif
    end
    if (mi_addr == ADDR_CTRL) rsel_c = DW'(gen_q);
    if (mi_addr == ADDR_STAT) rsel_c = DW'(flag_q);
    rdata_d = rd_c ? rsel_c : rdata_q;
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= '0;
      dir_q   <= '0;
      sat_q   <= '0;
      irqen_q <= '0;
      flag_q  <= '0;
      gen_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      sat_q   <= sat_d;
      irqen_q <= irqen_d;
      flag_q  <= flag_d;
      gen_q   <= gen_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign mi_data_out    = rdata_q;
  assign emon_zero_flag = flag_q;
  assign emon_irq       = irq_q;

endmodule

// File: tb/tb_emon_mcounter.sv
// Self-checking bench for emon_mcounter (CW=8 to exercise wrap/saturate boundaries).
module tb_emon_mcounter;
  localparam int unsigned DW = 32, CW = 8, MONS = 6, EW = 12, SELW = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            mi_access = 1'b0;
  logic            mi_write = 1'b0;
  logic [5:0]      mi_addr = '0;
  logic [DW-1:0]   mi_data_in = '0;
  logic [DW-1:0]   mi_data_out;
  logic [EW-1:0]   emon_events = '0;
  logic [MONS-1:0] emon_zero_flag;
  logic            emon_irq;

  int n_cmp = 0;
  int n_err = 0;

  emon_mcounter #(.DW(DW), .CW(CW), .MONS(MONS), .EW(EW), .SELW(SELW)) dut (
    .clk(clk), .reset_n(reset_n), .mi_access(mi_access), .mi_write(mi_write),
    .mi_addr(mi_addr), .mi_data_in(mi_data_in), .mi_data_out(mi_data_out),
    .emon_events(emon_events), .emon_zero_flag(emon_zero_flag), .emon_irq(emon_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mi_wr(input logic [5:0] a, input logic [31:0] d);
    mi_access = 1'b1; mi_write = 1'b1; mi_addr = a; mi_data_in = d;
    tick();
    mi_access = 1'b0; mi_write = 1'b0; mi_data_in = '0;
  endtask

  task automatic mi_rd(input logic [5:0] a, output logic [31:0] d);
    mi_access = 1'b1; mi_write = 1'b0; mi_addr = a;
    tick();
    mi_access = 1'b0;
    d = mi_data_out;
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    mi_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic pulse();
    emon_events = 12'h001;
    tick();
    emon_events = '0;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mi_access = 1'b0; mi_write = 1'b0; emon_events = '0;
    tick(2);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 6'h10, 32'hFFFF_FFFF, 32'h0000_0F0F};
    vecs[1]  = '{1'b1, 6'h15, 32'h0000_0A05, 32'h0000_0A05};
    vecs[2]  = '{1'b1, 6'h03, 32'h1234_56AB, 32'h0000_00AB};
    vecs[3]  = '{1'b1, 6'h05, 32'h0000_00FF, 32'h0000_00FF};
    vecs[4]  = '{1'b1, 6'h06, 32'h0000_0055, 32'h0000_0000};
    vecs[5]  = '{1'b1, 6'h16, 32'h0000_0055, 32'h0000_0000};
    vecs[6]  = '{1'b1, 6'h2A, 32'h0000_0055, 32'h0000_0000};
    vecs[7]  = '{1'b1, 6'h3F, 32'h0000_0055, 32'h0000_0000};
    vecs[8]  = '{1'b1, 6'h20, 32'hFFFF_FFF8, 32'h0000_0000};
    vecs[9]  = '{1'b1, 6'h21, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{1'b0, 6'h03, 32'h0000_0000, 32'h0000_00AB};
    vecs[11] = '{1'b1, 6'h20, 32'h0000_0002, 32'h0000_0000};
    vecs[12] = '{1'b0, 6'h03, 32'h0000_0000, 32'h0000_0000};
    vecs[13] = '{1'b0, 6'h05, 32'h0000_0000, 32'h0000_0000};
    vecs[14] = '{1'b0, 6'h10, 32'h0000_0000, 32'h0000_0F0F};

    // Reset state and full map readback
    do_reset();
    check("rst_data_out", mi_data_out, 32'h0);
    check("rst_flag", 32'(emon_zero_flag), 32'h0);
    check("rst_irq", 32'(emon_irq), 32'h0);
    for (int a = 0; a < 64; a++) rd_chk($sformatf("rst_map_%02h", a), 6'(a), 32'h0);

    // Register map vectors with counting frozen
    for (int v = 0; v < 15; v++) begin
      logic [31:0] d;
      if (vecs[v].wr) mi_wr(vecs[v].addr, vecs[v].wd);
      mi_rd(vecs[v].addr, d);
      check($sformatf("vec%0d_addr%02h", v, vecs[v].addr), d, vecs[v].exp);
    end

    // Free-running count of every clock
    do_reset();
    mi_wr(6'h10, 32'h101);
    mi_wr(6'h20, 32'h1);
    tick(10);
    rd_chk("count10", 6'h00, 32'd10);
    tick();
    check("read_hold", mi_data_out, 32'd10);
    mi_wr(6'h00, 32'h40);
    rd_chk("write_beats_count", 6'h00, 32'h40);
    mi_wr(6'h10, 32'h001);
    rd_chk("old_cfg_counts", 6'h00, 32'h42);

`ifdef EMON_SNAPSHOT_EN
    mi_wr(6'h10, 32'h101);
    tick(3);
    mi_wr(6'h20, 32'h5);
    tick(4);
    rd_chk("snap_shadow", 6'h30, 32'h45);
    rd_chk("snap_live", 6'h00, 32'h4B);
    mi_wr(6'h20, 32'h3);
    rd_chk("snap_after_clear", 6'h30, 32'h45);
    rd_chk("snap_ctrl_rb", 6'h20, 32'h1);
`else
    mi_wr(6'h20, 32'h5);
    rd_chk("nosnap_shadow", 6'h30, 32'h0);
    rd_chk("nosnap_ctrl_rb", 6'h20, 32'h1);
`endif

    // Up wrap with interrupt, W1C racing a wrap
    do_reset();
    mi_wr(6'h01, 32'hFE);
    mi_wr(6'h11, 32'h901);
    mi_wr(6'h20, 32'h1);
    tick();
    check("wrap_pre_flag", 32'(emon_zero_flag[1]), 32'h0);
    check("wrap_pre_irq", 32'(emon_irq), 32'h0);
    tick();
    check("wrap_flag", 32'(emon_zero_flag[1]), 32'h1);
    check("wrap_irq", 32'(emon_irq), 32'h1);
    mi_wr(6'h20, 32'h0);
    rd_chk("wrap_cnt", 6'h01, 32'h01);
    mi_wr(6'h21, 32'h2);
    check("w1c_flag", 32'(emon_zero_flag[1]), 32'h0);
    check("w1c_irq", 32'(emon_irq), 32'h0);
    mi_wr(6'h01, 32'hFF);
    mi_wr(6'h20, 32'h1);
    mi_wr(6'h21, 32'h2);
    check("set_beats_w1c", 32'(emon_zero_flag[1]), 32'h1);
    mi_wr(6'h20, 32'h0);
    mi_wr(6'h11, 32'h101);
    check("irq_masked", 32'(emon_irq), 32'h0);
    rd_chk("status_rb", 6'h21, 32'h2);

    // Down count on event 0, saturating then wrapping
    do_reset();
    mi_wr(6'h02, 32'h3);
    mi_wr(6'h12, 32'h702);
    mi_wr(6'h20, 32'h1);
    pulse(); pulse();
    check("down_flag_early", 32'(emon_zero_flag[2]), 32'h0);
    rd_chk("down_cnt1", 6'h02, 32'h1);
    pulse();
    check("down_flag_zero", 32'(emon_zero_flag[2]), 32'h1);
    mi_wr(6'h21, 32'h4);
    pulse(); pulse();
    check("down_sat_noflag", 32'(emon_zero_flag[2]), 32'h0);
    rd_chk("down_sat_cnt", 6'h02, 32'h0);
    mi_wr(6'h12, 32'h302);
    pulse();
    check("down_wrap_flag", 32'(emon_zero_flag[2]), 32'h1);
    rd_chk("down_wrap_cnt", 6'h02, 32'hFF);
    pulse();
    rd_chk("down_after_wrap", 6'h02, 32'hFE);

    // Up saturation at max
    mi_wr(6'h03, 32'hFD);
    mi_wr(6'h13, 32'h501);
    tick();
    check("upsat_pre_flag", 32'(emon_zero_flag[3]), 32'h0);
    tick();
    check("upsat_flag", 32'(emon_zero_flag[3]), 32'h1);
    tick(3);
    rd_chk("upsat_cnt", 6'h03, 32'hFF);
    mi_wr(6'h21, 32'h8);
    tick(2);
    check("upsat_noflag_at_max", 32'(emon_zero_flag[3]), 32'h0);

    // clear_all while counting with a flag pending
    mi_wr(6'h21, 32'h0);
    check("pre_clear_flags", 32'(emon_zero_flag), 32'h04);
    mi_wr(6'h20, 32'h3);
    check("clear_flags", 32'(emon_zero_flag), 32'h0);
    rd_chk("clear_cnt3", 6'h03, 32'h0);
    rd_chk("clear_cnt2", 6'h02, 32'h0);
    rd_chk("clear_ctrl_rb", 6'h20, 32'h1);

    // Asynchronous reset mid-count
    rd_chk("pre_rst_cfg", 6'h13, 32'h501);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_data", mi_data_out, 32'h0);
    check("async_rst_irq", 32'(emon_irq), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    rd_chk("post_rst_cnt", 6'h03, 32'h0);
    rd_chk("post_rst_cfg", 6'h13, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
